// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes, FSM
// state encoding and the iteration-counter width helper.
package mdu_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } mdu_state_e;

    // Counter must hold the value WIDTH itself, hence WIDTH+1.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for
// divide. acc is the upper half (partial product / remainder), qr the lower half.
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic             div_mode,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] qr,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] acc_nxt,
    output logic [WIDTH-1:0] qr_nxt
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] diff;
    logic             ge;

    always_comb begin
        sum    = {1'b0, acc} + {1'b0, opnd};
        rem_sh = {acc, qr[WIDTH-1]};
        // rem_sh < 2*opnd, so when it fits the true difference is below 2^WIDTH
        ge     = (rem_sh >= {1'b0, opnd});
        diff   = rem_sh[WIDTH-1:0] - opnd;

        acc_nxt = acc;
        qr_nxt  = qr;
        if (div_mode) begin
            if (ge) begin
                acc_nxt = diff;
                qr_nxt  = {qr[WIDTH-2:0], 1'b1};
            end else begin
                acc_nxt = rem_sh[WIDTH-1:0];
                qr_nxt  = {qr[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (qr[0]) begin
                {acc_nxt, qr_nxt} = {sum, qr[WIDTH-1:1]};
            end else begin
                {acc_nxt, qr_nxt} = {1'b0, acc, qr[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit owning HI/LO. Multi-cycle ops run WIDTH
// radix-2 steps on operand magnitudes, then a sign-fix cycle writes HI/LO.
//
// state   | meaning
// IDLE    | waiting; accepts MULT/DIV (to RUN) or MTHI/MTLO (immediate write)
// RUN     | one iteration per cycle, WIDTH cycles
// FIX     | sign correction, HI/LO write, done pulse next cycle
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = cnt_width(WIDTH);

    mdu_state_e       state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] qr_q;
    logic [WIDTH-1:0] opnd_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             is_div_q;
    logic             neg_lo_q;
    logic             neg_hi_q;
    logic             dz_q;
    logic             done_q;

    logic [WIDTH-1:0] acc_d;
    logic [WIDTH-1:0] qr_d;

    logic             is_mc;
    logic             is_div_op;
    logic             is_signed;
    logic             sa;
    logic             sb;
    logic             dz;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .div_mode (is_div_q),
        .acc      (acc_q),
        .qr       (qr_q),
        .opnd     (opnd_q),
        .acc_nxt  (acc_d),
        .qr_nxt   (qr_d)
    );

    always_comb begin
        is_div_op = (op == OP_DIV) || (op == OP_DIVU);
        is_mc     = is_div_op || (op == OP_MULT) || (op == OP_MULTU);
        is_signed = (op == OP_MULT) || (op == OP_DIV);
        sa        = is_signed & a[WIDTH-1];
        sb        = is_signed & b[WIDTH-1];
        mag_a     = sa ? -a : a;
        mag_b     = sb ? -b : b;
        dz        = is_div_op && (b == '0);
    end

    always_comb begin
        prod_fix = neg_lo_q ? -{acc_q, qr_q} : {acc_q, qr_q};
        res_hi   = prod_fix[2*WIDTH-1:WIDTH];
        res_lo   = prod_fix[WIDTH-1:0];
        if (is_div_q) begin
            if (dz_q) begin
                res_hi = acc_q;
                res_lo = '1;
            end else begin
                res_hi = neg_hi_q ? -acc_q : acc_q;
                res_lo = neg_lo_q ? -qr_q : qr_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            qr_q     <= '0;
            opnd_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            dz_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start && !cancel) begin
                        if (is_mc) begin
                            state_q  <= ST_RUN;
                            cnt_q    <= CW'(WIDTH);
                            acc_q    <= '0;
                            is_div_q <= is_div_op;
                            dz_q     <= dz;
                            if (is_div_op) begin
                                // Divide by zero runs on the raw dividend so the
                                // remainder comes out equal to a unchanged.
                                qr_q     <= dz ? a : mag_a;
                                opnd_q   <= mag_b;
                                neg_lo_q <= ~dz & (sa ^ sb);
                                neg_hi_q <= ~dz & sa;
                            end else begin
                                qr_q     <= mag_b;
                                opnd_q   <= mag_a;
                                neg_lo_q <= sa ^ sb;
                                neg_hi_q <= 1'b0;
                            end
                        end else if (op == OP_MTHI) begin
                            hi_q <= a;
                        end else if (op == OP_MTLO) begin
                            lo_q <= a;
                        end
                    end
                end
                ST_RUN: begin
                    if (cancel) begin
                        state_q <= ST_IDLE;
                    end else begin
                        acc_q <= acc_d;
                        qr_q  <= qr_d;
                        cnt_q <= cnt_q - CW'(1);
                        if (cnt_q == CW'(1)) begin
                            state_q <= ST_FIX;
                        end
                    end
                end
                ST_FIX: begin
                    state_q <= ST_IDLE;
                    if (!cancel) begin
                        hi_q   <= res_hi;
                        lo_q   <= res_lo;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
